// File: rtl/pipeline_pkg.sv
// Purpose: shared pipeline types for the RV32IM core: redirect FSM encoding, PC width, NOP word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_pkg;

   // Redirect sequencer states; encodings are relied on by debug tooling, keep them fixed.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      SQUASH  = 2'd2
   } redir_state_t;

   localparam int DEFAULT_ADDR_W = 32;

   // addi x0, x0, 0 -- the canonical RV32I NOP that flushed pipeline registers hold.
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/pc_redirect_controller.sv
// Purpose: holds an EX-stage branch/jump redirect until IF accepts it, drives the PC mux and squashes wrong-path work.
// Latency: req sampled at edge N -> pc_sel/flushes high in cycle N+1; target fetched at the first edge with fetch_ready.
// Backpressure: fetch_ready low keeps PENDING (pc_sel, flushes, pc_target) held indefinitely; new reqs while busy are dropped.
//
// Ports:
//   CLK, RESET            clock and asynchronous active-high reset
//   ex_valid              EX holds a real, non-stalled instruction
//   PCAddressController   EX decision: take TargetedAddress
//   TargetedAddress       redirect target from EX
//   fetch_ready           IF accepts a new PC at this edge
//   pc_sel                PC mux selects pc_target
//   pc_target             latched redirect target
//   flush_ifid/flush_idex clear the pipeline register to NOP at the next edge
//   busy                  sequencer not idle
//   misalign              one-cycle pulse for a rejected target with [1:0] != 0
//   redirect_count        redirects accepted by IF, wraps silently
module pc_redirect_controller
   import pipeline_pkg::*;
#(
   parameter int ADDR_W        = DEFAULT_ADDR_W,
   parameter int SQUASH_CYCLES = 2,
   parameter int CNT_W         = 16
)(
   input  logic              CLK,
   input  logic              RESET,
   input  logic              ex_valid,
   input  logic              PCAddressController,
   input  logic [ADDR_W-1:0] TargetedAddress,
   input  logic              fetch_ready,
   output logic              pc_sel,
   output logic [ADDR_W-1:0] pc_target,
   output logic              flush_ifid,
   output logic              flush_idex,
   output logic              busy,
   output logic              misalign,
   output logic [CNT_W-1:0]  redirect_count
);

   // $clog2(1) is 0, so a zero-length squash still gets a 1-bit counter.
   localparam int SQ_W = (SQUASH_CYCLES > 0) ? $clog2(SQUASH_CYCLES + 1) : 1;
   // The counter runs load..0 inclusive, so loading N-1 gives exactly N squash cycles.
   localparam logic [SQ_W-1:0] SQ_LOAD = (SQUASH_CYCLES > 0) ? SQ_W'(SQUASH_CYCLES - 1) : '0;

   redir_state_t      state_q, state_nxt;
   logic [ADDR_W-1:0] target_q, target_nxt;
   logic [SQ_W-1:0]   sq_cnt_q, sq_cnt_nxt;
   logic              mis_q, mis_nxt;
   logic [CNT_W-1:0]  cnt_q, cnt_nxt;

   logic req;
   logic aligned;

   assign req     = ex_valid & PCAddressController;
   assign aligned = (TargetedAddress[1:0] == 2'b00);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= IDLE;
         target_q <= '0;
         sq_cnt_q <= '0;
         mis_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_nxt;
         target_q <= target_nxt;
         sq_cnt_q <= sq_cnt_nxt;
         mis_q    <= mis_nxt;
         cnt_q    <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt  = state_q;
      target_nxt = target_q;
      sq_cnt_nxt = sq_cnt_q;
      mis_nxt    = 1'b0;
      cnt_nxt    = cnt_q;

      case (state_q)
         IDLE: begin
            if (req) begin
               if (aligned) begin
                  target_nxt = TargetedAddress;
                  state_nxt  = PENDING;
               end else begin
                  mis_nxt = 1'b1;
               end
            end
         end
         // Any req seen while PENDING or SQUASH comes from the wrong path and is dropped.
         PENDING: begin
            if (fetch_ready) begin
               cnt_nxt = cnt_q + 1'b1;
               if (SQUASH_CYCLES == 0) begin
                  state_nxt = IDLE;
               end else begin
                  sq_cnt_nxt = SQ_LOAD;
                  state_nxt  = SQUASH;
               end
            end
         end
         SQUASH: begin
            if (sq_cnt_q == '0) begin
               state_nxt = IDLE;
            end else begin
               sq_cnt_nxt = sq_cnt_q - 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Moore decode only: no input reaches an output without passing a flop.
   assign pc_sel         = (state_q == PENDING);
   assign flush_idex     = (state_q == PENDING);
   assign flush_ifid     = (state_q == PENDING) || (state_q == SQUASH);
   assign busy           = (state_q != IDLE);
   assign pc_target      = target_q;
   assign misalign       = mis_q;
   assign redirect_count = cnt_q;

endmodule
